// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte buffer behind the UART receiver, with a sticky overflow flag.
// Define UART_RX_FIFO_DROP_CNT_EN to build the saturating dropped-byte counter; otherwise drop_cnt reads 0.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic [7:0]    in_data,
  input  logic          in_err,
  input  logic          in_valid,
  output logic [7:0]    out_data,
  output logic          out_err,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overflow,
  output logic [7:0]    drop_cnt
);

  logic [8:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [8:0]  head;
  logic        empty;
  logic        pop;
  logic        push;
  logic        drop;

  // Wrap bit (MSB) distinguishes full from empty when the address bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop   = !empty && out_ready;
  assign push  = in_valid && (!full || pop);
  assign drop  = in_valid && full && !pop;
  assign count = wr_ptr - rd_ptr;

  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_valid = !empty;
  assign out_data  = empty ? 8'h00 : head[7:0];
  assign out_err   = empty ? 1'b0  : head[8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage is deliberately left unreset; only pointers and flags define validity.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr[AW-1:0]] <= {in_err, in_data};
  end

`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [7:0] drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= 8'h00;
    end else if (clear) begin
      drop_q <= 8'h00;
    end else if (drop && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'h01;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 8'h00;
`endif

endmodule
